// File: rtl/hash_arb_pkg.sv
// rtl/hash_arb_pkg.sv - shared types and byte-array helpers for the hash core arbiter
package hash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int HASH_BYTES   = 4;
  localparam int CORE_LATENCY = 26;

  typedef logic [0:HASH_BYTES-1][7:0] hash_bytes_t;

  // Byte 0 of the flat word sits in bits [7:0] and maps to array element 0.
  function automatic hash_bytes_t unpack_bytes(input logic [8*HASH_BYTES-1:0] v);
    hash_bytes_t a;
    for (int i = 0; i < HASH_BYTES; i++) begin
      a[i] = v[8*i +: 8];
    end
    return a;
  endfunction

  function automatic logic [8*HASH_BYTES-1:0] pack_bytes(input hash_bytes_t a);
    logic [8*HASH_BYTES-1:0] v;
    for (int i = 0; i < HASH_BYTES; i++) begin
      v[8*i +: 8] = a[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/hash_rr_picker.sv
// rtl/hash_rr_picker.sv - round-robin selector: first valid requester at or after ptr
module hash_rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     any_valid
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W:0]   idx;
  logic [PTR_W-1:0] idx_n;

  // Walk from the farthest offset down so the nearest valid port overwrites last.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx       = '0;
    idx_n     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N_REQ)) begin
        idx = idx - (PTR_W+1)'(N_REQ);
      end
      idx_n = idx[PTR_W-1:0];
      if (req[idx_n]) begin
        sel       = idx_n;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// rtl/hash_arbiter.sv - round-robin sharing of one hash core between N_REQ requesters
module hash_arbiter
  import hash_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*32-1:0]          req_m,
  input  logic [N_REQ*32-1:0]          req_iv,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic [31:0]                  rsp_d,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         core_start,
  output logic [0:HASH_BYTES-1][7:0]   core_m,
  output logic [0:HASH_BYTES-1][7:0]   core_iv,
  input  logic [0:HASH_BYTES-1][7:0]   core_d,
  input  logic                         core_done
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [31:0]        m_q, m_d;
  logic [31:0]        iv_q, iv_d;
  logic [31:0]        d_q, d_d;
  logic               err_q, err_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] timer_inc;

  logic [PTR_W-1:0]   sel;
  logic               any_valid;
  logic               drive_core;

  hash_rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req      (req_valid),
    .ptr      (ptr_q),
    .sel      (sel),
    .any_valid(any_valid)
  );

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    m_d        = m_q;
    iv_d       = iv_q;
    d_d        = d_q;
    err_d      = err_q;
    timer_d    = timer_q;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gating on rst_n keeps the grant quiet while reset is held.
        if (any_valid && rst_n) begin
          req_ready[sel] = 1'b1;
          owner_d        = sel;
          m_d            = req_m[32*sel +: 32];
          iv_d           = req_iv[32*sel +: 32];
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        timer_d    = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        timer_d = timer_inc;
        // A done in the same cycle as the abort still wins.
        if (core_done) begin
          d_d     = pack_bytes(core_d);
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_inc == TIMER_LAST) begin
          d_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      m_q     <= '0;
      iv_q    <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      m_q     <= m_d;
      iv_q    <= iv_d;
      d_q     <= d_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // The core samples its inputs every round, so they come straight from the latched copies.
  assign drive_core = (state_q == ISSUE) || (state_q == WAIT);
  assign core_m     = drive_core ? unpack_bytes(m_q)  : '0;
  assign core_iv    = drive_core ? unpack_bytes(iv_q) : '0;
  assign busy       = (state_q != IDLE);
  assign rsp_d      = (state_q == RESP) ? d_q : '0;
  assign rsp_err    = (state_q == RESP) && err_q;

endmodule
